// File: rtl/oam_dma_arbiter_pkg.sv
// Shared definitions for the OAM page-copy DMA arbiter: FSM state
// encodings and the default register / destination bus addresses.
package oam_dma_arbiter_pkg;

    localparam logic [2:0] DMA_IDLE  = 3'd0;
    localparam logic [2:0] DMA_HALT  = 3'd1;
    localparam logic [2:0] DMA_ALIGN = 3'd2;
    localparam logic [2:0] DMA_READ  = 3'd3;
    localparam logic [2:0] DMA_WRITE = 3'd4;

    localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h4014;
    localparam logic [15:0] DMA_DST_ADDR_DEF = 16'h2004;

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: sits between the CPU and memory/IO decode, snoops CPU
// writes to the DMA register, stalls the CPU through its ready input and
// copies one 256-byte page to a fixed destination port, one read/write
// pair per byte, before handing the bus back.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
    parameter logic [15:0] DMA_DST_ADDR = DMA_DST_ADDR_DEF,
    parameter bit          ALIGN_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_data_o,
    output logic        cpu_ready,
    output logic [15:0] mem_address,
    output logic        mem_write,
    output logic [7:0]  mem_data_o,
    input  logic [7:0]  mem_data_i,
    output logic        dma_busy,
    output logic        dma_done
);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_parity;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_buf;
    logic       r_cpu_ready;
    logic       r_busy;
    logic       r_done;
    logic       w_trigger;
    logic       w_last;

    assign w_trigger = cpu_write && (cpu_address == DMA_REG_ADDR);
    assign w_last    = (r_idx == 8'hFF);

    assign cpu_ready = r_cpu_ready;
    assign dma_busy  = r_busy;
    assign dma_done  = r_done;

    // Next-state logic; HALT waits for the CPU to reach a read cycle since
    // the 6502 ignores ready while writing.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DMA_IDLE:  w_state_nxt = w_trigger ? DMA_HALT : DMA_IDLE;
            DMA_HALT: begin
                if (cpu_write)
                    w_state_nxt = DMA_HALT;
                else if (ALIGN_EN && !r_parity)
                    w_state_nxt = DMA_ALIGN;
                else
                    w_state_nxt = DMA_READ;
            end
            DMA_ALIGN: w_state_nxt = DMA_READ;
            DMA_READ:  w_state_nxt = DMA_WRITE;
            DMA_WRITE: w_state_nxt = w_last ? DMA_IDLE : DMA_READ;
            default:   w_state_nxt = DMA_IDLE;
        endcase
    end

    // State register plus the outputs registered from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= DMA_IDLE;
            r_cpu_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cpu_ready <= (w_state_nxt == DMA_IDLE);
            r_busy      <= (w_state_nxt != DMA_IDLE);
            r_done      <= (r_state == DMA_WRITE) && w_last;
        end
    end

    // Free-running cycle parity; the first cycle after reset release is even.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_parity <= 1'b0;
        else
            r_parity <= ~r_parity;
    end

    // Page capture (last write wins while halting), byte index and data buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_page <= 8'h00;
            r_idx  <= 8'h00;
            r_buf  <= 8'h00;
        end else begin
            if (((r_state == DMA_IDLE) || (r_state == DMA_HALT)) && w_trigger)
                r_page <= cpu_data_o;
            if ((r_state == DMA_IDLE) && w_trigger)
                r_idx <= 8'h00;
            else if ((r_state == DMA_WRITE) && !w_last)
                r_idx <= r_idx + 8'h01;
            if (r_state == DMA_READ)
                r_buf <= mem_data_i;
        end
    end

    // Bus mux: the CPU owns the bus in IDLE and HALT, the DMA engine otherwise.
    // The read index never carries into the page byte.
    always_comb begin
        mem_address = cpu_address;
        mem_write   = cpu_write;
        mem_data_o  = cpu_data_o;
        case (r_state)
            DMA_ALIGN, DMA_READ: begin
                mem_address = {r_page, r_idx};
                mem_write   = 1'b0;
                mem_data_o  = r_buf;
            end
            DMA_WRITE: begin
                mem_address = DMA_DST_ADDR;
                mem_write   = 1'b1;
                mem_data_o  = r_buf;
            end
            default: begin
                mem_address = cpu_address;
                mem_write   = cpu_write;
                mem_data_o  = cpu_data_o;
            end
        endcase
    end

endmodule
